// File: rtl/matrix_processing_unit.sv
// matrix_processing_unit: worker that takes one (row, column) index pair and computes
// the dot product of row A[row] with column B[col] through a synchronous read port.
module matrix_processing_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] A_BASE = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] B_BASE = 16'h1000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [31:0]           i_Config,
  input  logic                  i_Indexes_Ready,
  input  logic [7:0]            i_Row_Index,
  input  logic [7:0]            i_Column_Index,
  output logic                  o_Indexes_Received,
  output logic                  o_Mem_Read_Enable,
  output logic [ADDR_WIDTH-1:0] o_Mem_Read_Address,
  input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic [7:0]            o_Result_Row,
  output logic [7:0]            o_Result_Column,
  output logic                  o_Index_Error,
  output logic                  o_Result_Ready,
  input  logic                  i_Result_Taken
);
  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, MAC, DONE} state_t;
  state_t state, state_next;
  logic [7:0] row, col, kdim, bcols, k;
  logic [DATA_WIDTH-1:0] acc, a;
  logic ack, err, capture, cap_err, cap_skip;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  assign capture = state == IDLE && !ack && i_Indexes_Ready;
  // K=0 alone is a valid empty product; dimension mismatch only matters when K is nonzero
  assign cap_err = i_Row_Index >= i_Config[31:24] || i_Column_Index >= i_Config[7:0] ||
                   (i_Config[23:16] != 8'd0 && i_Config[23:16] != i_Config[15:8]);
  assign cap_skip = cap_err || i_Config[23:16] == 8'd0;
  assign a_addr = A_BASE + ADDR_WIDTH'(row) * ADDR_WIDTH'(kdim) + ADDR_WIDTH'(k);
  assign b_addr = B_BASE + ADDR_WIDTH'(k) * ADDR_WIDTH'(bcols) + ADDR_WIDTH'(col);
  assign o_Mem_Read_Enable = state == FETCH_A || state == FETCH_B;
  assign o_Mem_Read_Address = state == FETCH_A ? a_addr : state == FETCH_B ? b_addr : '0;
  assign o_Result = acc;
  assign o_Result_Row = row;
  assign o_Result_Column = col;
  assign o_Index_Error = err;
  assign o_Result_Ready = state == DONE;
  assign o_Indexes_Received = ack;
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = capture ? (cap_skip ? DONE : FETCH_A) : IDLE;
      FETCH_A: state_next = FETCH_B;
      FETCH_B: state_next = MAC;
      MAC:     state_next = k == kdim - 8'd1 ? DONE : FETCH_A;
      DONE:    state_next = i_Result_Taken ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      ack <= 1'b0;
      err <= 1'b0;
      row <= '0;
      col <= '0;
      kdim <= '0;
      bcols <= '0;
      k <= '0;
      acc <= '0;
      a <= '0;
    end else begin
      ack <= ack ? i_Indexes_Ready : capture;
      if (capture) begin
        row <= i_Row_Index;
        col <= i_Column_Index;
        kdim <= i_Config[23:16];
        bcols <= i_Config[7:0];
        err <= cap_err;
        k <= '0;
        acc <= '0;
      end
      if (state == FETCH_B) a <= i_Mem_Read_Data;
      if (state == MAC) begin
        acc <= acc + a * i_Mem_Read_Data;
        k <= k + 8'd1;
      end
    end
endmodule

// File: doc/matrix_processing_unit.md
# matrix_processing_unit

Worker-side counterpart of the main control unit's index-dispatch protocol. The block accepts one (row, column) index pair from the control unit over a ready/received handshake, then computes the dot product of row `row` of matrix A with column `col` of matrix B by reading operands through a synchronous memory port. It presents the result with a ready/taken handshake. Four instances sit beside the control unit, one per bit of its `Indexes_Ready` vector.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `ADDR_WIDTH`, 16: memory address width.
- `A_BASE`, 16'h0000: word address of A[0][0]; A is stored row-major.
- `B_BASE`, 16'h1000: word address of B[0][0]; B is stored row-major.
- `i_Clock` input 1: single clock; all state updates on the rising edge.
- `i_Reset` input 1: reset, asynchronous, active-low.
- `i_Config` input 32: matrix dimensions.
  - [31:24] A rows.
  - [23:16] A cols (K).
  - [15:8] B rows.
  - [7:0] B cols.
- `i_Indexes_Ready` input 1: this unit's bit of the control unit's `Indexes_Ready`.
- `i_Row_Index` input 8: row of A to use.
- `i_Column_Index` input 8: column of B to use.
- `o_Indexes_Received` output 1: index acknowledge.
- `o_Mem_Read_Enable` output 1: read strobe.
- `o_Mem_Read_Address` output ADDR_WIDTH: read address.
- `i_Mem_Read_Data` input DATA_WIDTH: read data, valid the cycle after the strobe.
- `o_Result` output DATA_WIDTH: dot-product result.
- `o_Result_Row` output 8: row index of the held result.
- `o_Result_Column` output 8: column index of the held result.
- `o_Index_Error` output 1: the held result is invalid (range or dimension error).
- `o_Result_Ready` output 1: result valid, held until taken.
- `i_Result_Taken` input 1: consumer accepts the result.

## Operation
- States: IDLE, FETCH_A, FETCH_B, MAC, DONE.
- **IDLE**
  - On a sampled `i_Indexes_Ready`=1, latch row, col and `i_Config`.
  - Clear the accumulator and set k=0.
  - Next state is FETCH_A.
  - Exceptions: if K=0, row ≥ A rows, col ≥ B cols, or A cols ≠ B rows, go directly to DONE with result 0. `o_Index_Error` is 1 except in the pure K=0 case.
- **FETCH_A**
  - Drive `o_Mem_Read_Enable`=1 with address A_BASE + row·K + k.
  - Next state is FETCH_B.
- **FETCH_B**
  - Drive address B_BASE + k·(B cols) + col.
  - Register `i_Mem_Read_Data` as operand a.
  - Next state is MAC.
- **MAC**
  - Compute acc ← acc + a·`i_Mem_Read_Data`.
  - Increment k.
  - Next state is DONE if the old k = K−1, otherwise FETCH_A.
- **DONE**
  - `o_Result_Ready`=1; `o_Result`, row, column and error are held stable.
  - On a sampled `i_Result_Taken`=1, go to IDLE.
- **Arithmetic**
  - Products and sums are two's-complement, truncated to DATA_WIDTH (wrap-around, no saturation).
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- **Acknowledge (independent of compute)**
  - `o_Indexes_Received` goes high the cycle after capture.
  - It stays high while `i_Indexes_Ready`=1.
  - It falls on the edge after `i_Indexes_Ready` is sampled 0.
- **No new capture** while not in IDLE or while `o_Indexes_Received`=1. A pending `i_Indexes_Ready` waits.
- **Inputs used from latches only**: `i_Config` and the index inputs are read only at capture. Changes mid-compute have no effect.

## Timing
- **Reset values**: state IDLE and every output 0 (`o_Indexes_Received`, `o_Mem_Read_Enable`, address, `o_Result`, row, column, `o_Index_Error`, `o_Result_Ready`).
- **Reset mid-operation**: asserting reset during any state aborts immediately and discards the accumulator.
- **Latency**
  - 3 cycles per k.
  - `o_Result_Ready` rises 3K cycles after the capture edge: 9 cycles for K=3.
  - Error and K=0 cases: `o_Result_Ready` rises 1 cycle after capture.
- **Memory timing**: `o_Mem_Read_Enable` is high in FETCH_A and FETCH_B only. Read data is sampled exactly one edge after the strobe.
- **DONE → IDLE**
  - `i_Result_Taken` sampled in DONE gives `o_Result_Ready`=0 on the next edge.
  - A new capture is possible on the edge after that at the earliest.
  - `i_Result_Taken` outside DONE is ignored.

## Test plan
1. Config 32'h03030303, A=1..9 row-major, B=identity; index (1,2) → `o_Indexes_Received` high one cycle after capture; `o_Result_Ready` 9 cycles after capture with `o_Result`=6, row 1, column 2, error 0. Address sequence is 3,0x1002,4,0x1005,5,0x1008.
2. Handshake: hold `i_Indexes_Ready` high for 5 cycles → ack stays high and drops one edge after Ready falls. Re-asserting Ready while computing → no recapture until DONE→IDLE and ack low.
3. Hold `i_Result_Taken`=0 for 10 cycles in DONE → outputs stable. Taken=1 → `o_Result_Ready` low next edge.
4. Index (3,0) with config 32'h03030303 → result 0, `o_Index_Error`=1, ready 1 cycle after capture, no memory reads. Config 32'h03000303 (K=0) → result 0, error 0.
5. Operands 32'h7FFFFFFF·2 plus −1·1 → result 32'hFFFFFFFD (wrap-around).
6. Reset pulse during MAC of k=1 → all outputs 0 immediately. A subsequent full computation gives the correct result.
